// File: rtl/inst_rom_loader_pkg.sv
// Widths and defaults shared between the CPU and its boot-time instruction ROM loader.
package inst_rom_loader_pkg;

  localparam int unsigned InstWidth    = 32;
  localparam int unsigned ByteWidth    = 8;
  localparam int unsigned LanesPerWord = InstWidth / ByteWidth;

  localparam logic [InstWidth-1:0] InstNop = 32'h0000_0000;

  // Big-endian lane placement: lane 0 lands in the most significant byte.
  function automatic logic [InstWidth-1:0] place_byte(input logic [ByteWidth-1:0] b,
                                                      input logic [1:0]           lane);
    return InstWidth'(b) << (ByteWidth * (LanesPerWord - 1 - int'(lane)));
  endfunction

endpackage

// File: rtl/inst_rom_loader_mem.sv
// Instruction storage: one synchronous write port, one combinational read port.
module inst_mem
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [InstWidth-1:0]  wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [InstWidth-1:0]  rdata_o
);

  logic [InstWidth-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_rom_loader.sv
// Assembles a byte stream into instruction words at boot, then serves CPU fetches.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned          DEPTH_LOG2 = 10,
  parameter logic [InstWidth-1:0] INST_NOP   = InstNop
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic [31:0]           addr_i,
  output logic [InstWidth-1:0]  inst_o,
  input  logic                  ld_valid_i,
  input  logic [ByteWidth-1:0]  ld_byte_i,
  input  logic                  ld_last_i,
  output logic                  ld_ready_o,
  output logic                  boot_done_o,
  output logic [DEPTH_LOG2:0]   word_cnt_o,
  output logic                  ovf_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  localparam logic [1:0]            LaneLast = 2'd3;
  localparam logic [DEPTH_LOG2-1:0] WptrMax  = '1;

  state_e                state_q, state_d;
  logic [1:0]            lane_q, lane_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [InstWidth-1:0]  word_q, word_d;

  logic                  accept;
  logic                  mem_we;
  logic [InstWidth-1:0]  word_asm;
  logic [InstWidth-1:0]  rdata;
  logic                  fetch_hit;
  logic                  unused_addr;

  assign accept   = ld_valid_i && ld_ready_o;
  // word_q holds only already-filled lanes; lower lanes stay zero for a partial final word.
  assign word_asm = word_q | place_byte(ld_byte_i, lane_q);

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    word_d  = word_q;
    mem_we  = 1'b0;
    if (accept) begin
      if (lane_q == LaneLast || ld_last_i) begin
        mem_we = 1'b1;
        wptr_d = wptr_q + 1'b1;
        cnt_d  = cnt_q + 1'b1;
        lane_d = '0;
        word_d = '0;
        if (ld_last_i) begin
          state_d = StDone;
        end else if (wptr_q == WptrMax) begin
          state_d = StDone;
          ovf_d   = 1'b1;
        end else begin
          state_d = StLoad;
        end
      end else begin
        lane_d  = lane_q + 1'b1;
        word_d  = word_asm;
        state_d = StLoad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lane_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      word_q  <= word_d;
    end
  end

  inst_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (wptr_q),
    .wdata_i (word_asm),
    .raddr_i (addr_i[DEPTH_LOG2+1:2]),
    .rdata_o (rdata)
  );

  // Byte offset within a word is irrelevant to word-aligned fetches.
  assign unused_addr = ^addr_i[1:0];

  assign fetch_hit   = ce_i && (state_q == StDone) && (addr_i[31:DEPTH_LOG2+2] == '0);
  assign inst_o      = fetch_hit ? rdata : INST_NOP;
  assign ld_ready_o  = (state_q != StDone);
  assign boot_done_o = (state_q == StDone);
  assign word_cnt_o  = cnt_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized bench for inst_rom_loader, checked against a byte-queue model of the image.
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst2 = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] addr = '0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic        ld_last = 1'b0;

  logic [31:0] inst;
  logic        ready, done, ovf;
  logic [10:0] cnt;
  logic [31:0] inst2;
  logic        ready2, done2, ovf2;
  logic [2:0]  cnt2;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [7:0] bq[$];

  always #5 clk = ~clk;

  inst_rom_loader #(.DEPTH_LOG2(10)) dut (
    .clk(clk), .rst(rst), .ce_i(ce), .addr_i(addr), .inst_o(inst),
    .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_last_i(ld_last),
    .ld_ready_o(ready), .boot_done_o(done), .word_cnt_o(cnt), .ovf_o(ovf)
  );

  inst_rom_loader #(.DEPTH_LOG2(2)) dut2 (
    .clk(clk), .rst(rst2), .ce_i(ce), .addr_i(addr), .inst_o(inst2),
    .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_last_i(ld_last),
    .ld_ready_o(ready2), .boot_done_o(done2), .word_cnt_o(cnt2), .ovf_o(ovf2)
  );

  // Word idx of the image: bytes 4*idx..4*idx+3, first byte most significant, missing bytes 0.
  function automatic logic [31:0] model_word(input int idx);
    logic [31:0] w = '0;
    for (int l = 0; l < 4; l++) begin
      if (4 * idx + l < bq.size()) w[31 - 8*l -: 8] = bq[4*idx + l];
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bq.delete();
  endtask

  task automatic fetch_check(input string name, input logic [31:0] a, input logic c,
                             input logic [31:0] exp);
    ce   = c;
    addr = a;
    #1;
    cmp_cnt++;
    if (inst !== exp) begin
      err_cnt++;
      $display("FAIL %s addr=%h: got %h expected %h", name, a, inst, exp);
    end
    ce = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ce  = 1'b1;
    addr = '0;
    tick();
    cmp_cnt++;
    if ({ready, done, ovf, cnt} !== {1'b1, 1'b0, 1'b0, 11'd0}) begin
      err_cnt++;
      $display("FAIL reset_state: got rdy=%b done=%b ovf=%b cnt=%0d expected 1 0 0 0",
               ready, done, ovf, cnt);
    end
    cmp_cnt++;
    if (inst !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_fetch: got %h expected 00000000", inst);
    end
    rst = 1'b0;
    ce  = 1'b0;
    bq.delete();
  endtask

  task automatic test_basic_load();
    logic [7:0] img [5] = '{8'h34, 8'h01, 8'h00, 8'h05, 8'hAA};
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      bq.push_back(img[i]);
      send(img[i], i == 4);
      if (i == 3) begin
        cmp_cnt++;
        if (done !== 1'b0 || cnt !== 11'd1) begin
          err_cnt++;
          $display("FAIL basic_mid: got done=%b cnt=%0d expected 0 1", done, cnt);
        end
        fetch_check("fetch_during_load", 32'h0, 1'b1, 32'h0);
      end
    end
    cmp_cnt++;
    if (done !== 1'b1 || cnt !== 11'd2 || ready !== 1'b0 || ovf !== 1'b0) begin
      err_cnt++;
      $display("FAIL basic_done: got done=%b cnt=%0d rdy=%b ovf=%b expected 1 2 0 0",
               done, cnt, ready, ovf);
    end
    fetch_check("basic_w0", 32'h0, 1'b1, 32'h3401_0005);
    fetch_check("basic_w1", 32'h4, 1'b1, 32'hAA00_0000);
    fetch_check("basic_w1_unaligned", 32'h7, 1'b1, model_word(1));
    fetch_check("basic_ce_low", 32'h4, 1'b0, 32'h0);
    fetch_check("basic_out_of_range", 32'h0000_1000, 1'b1, 32'h0);
    // Bytes offered in DONE must be ignored.
    send(8'h99, 1'b0);
    send(8'h98, 1'b1);
    cmp_cnt++;
    if (cnt !== 11'd2 || done !== 1'b1) begin
      err_cnt++;
      $display("FAIL done_absorbing: got cnt=%0d done=%b expected 2 1", cnt, done);
    end
    fetch_check("done_absorbing_w1", 32'h4, 1'b1, 32'hAA00_0000);
  endtask

  task automatic test_reset_mid_load();
    reset_dut();
    ld_last = 1'b1;
    tick();
    ld_last = 1'b0;
    cmp_cnt++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL last_without_valid: got done=%b rdy=%b expected 0 1", done, ready);
    end
    for (int i = 0; i < 6; i++) send(8'($urandom), 1'b0);
    // Reset wins over a simultaneous accepted byte.
    rst = 1'b1;
    send(8'hEE, 1'b1);
    rst = 1'b0;
    bq.delete();
    cmp_cnt++;
    if (done !== 1'b0 || cnt !== 11'd0) begin
      err_cnt++;
      $display("FAIL reset_priority: got done=%b cnt=%0d expected 0 0", done, cnt);
    end
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    cmp_cnt++;
    if (done !== 1'b1 || cnt !== 11'd1 || ovf !== 1'b0) begin
      err_cnt++;
      $display("FAIL reload_status: got done=%b cnt=%0d ovf=%b expected 1 1 0", done, cnt, ovf);
    end
    fetch_check("reload_w0", 32'h0, 1'b1, 32'h1122_3344);
  endtask

  task automatic run_random_image(input int n, input string name);
    int nwords;
    reset_dut();
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      while ($urandom_range(0, 1) == 1) tick();
      b = 8'($urandom);
      bq.push_back(b);
      send(b, i == n - 1);
    end
    nwords = (n + 3) / 4;
    cmp_cnt++;
    if (done !== 1'b1 || cnt !== 11'(nwords) || ovf !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_status: got done=%b cnt=%0d ovf=%b expected 1 %0d 0",
               name, done, cnt, ovf, nwords);
    end
    for (int w = 0; w < nwords; w++) begin
      fetch_check(name, 32'(4 * w) | 32'($urandom_range(0, 3)), 1'b1, model_word(w));
    end
  endtask

  task automatic test_random_gaps();
    run_random_image(256, "rand64");
    run_random_image($urandom_range(1, 30), "rand_partial");
    run_random_image(1, "rand_one");
  endtask

  task automatic test_overflow();
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    bq.delete();
    for (int k = 1; k <= 20; k++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (k <= 16) bq.push_back(b);
      send(b, 1'b0);
      if (k == 15) begin
        cmp_cnt++;
        if (done2 !== 1'b0 || ovf2 !== 1'b0 || cnt2 !== 3'd3) begin
          err_cnt++;
          $display("FAIL ovf_before: got done=%b ovf=%b cnt=%0d expected 0 0 3",
                   done2, ovf2, cnt2);
        end
      end else if (k >= 16) begin
        cmp_cnt++;
        if (done2 !== 1'b1 || ovf2 !== 1'b1 || cnt2 !== 3'd4 || ready2 !== 1'b0) begin
          err_cnt++;
          $display("FAIL ovf_after_%0d: got done=%b ovf=%b cnt=%0d rdy=%b expected 1 1 4 0",
                   k, done2, ovf2, cnt2, ready2);
        end
      end
    end
    for (int w = 0; w < 4; w++) begin
      ce = 1'b1;
      addr = 32'(4 * w);
      #1;
      cmp_cnt++;
      if (inst2 !== model_word(w)) begin
        err_cnt++;
        $display("FAIL ovf_word%0d: got %h expected %h", w, inst2, model_word(w));
      end
    end
    addr = 32'h10;
    #1;
    cmp_cnt++;
    if (inst2 !== 32'h0) begin
      err_cnt++;
      $display("FAIL ovf_out_of_range: got %h expected 00000000", inst2);
    end
    ce = 1'b0;
  endtask

  initial begin
    rst2 = 1'b1;
    test_reset();
    test_basic_load();
    test_reset_mid_load();
    test_random_gaps();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
